piezo_tone_gen: RTL and testbench
=================================

Name: piezo_tone_gen

Overview:
Parametrised successor to the single-octave keypad piezo driver. It maps an N-key one-hot/any-hot keypad onto a per-key half-period table and drives a square wave on PIEZO. It adds key synchronisation, priority resolution, glitch-free note changes at half-period boundaries, and a release sustain. It sits between the keypad input pins and the piezo output pin.

Parameters:
N_KEYS, 8, number of key inputs (2..16)
IDX_W, 3, width of NOTE output; must satisfy 2^IDX_W >= N_KEYS
CNT_W, 8, width of half-period counter and of each table entry
LIMIT_TABLE, {8'd190,8'd169,8'd151,8'd142,8'd127,8'd113,8'd100,8'd95}, packed N_KEYS*CNT_W vector; entry i = LIMIT_TABLE[i*CNT_W +: CNT_W] is terminal count T for KEY[i]; default gives KEY[7]=DO (190) down to KEY[0]=high DO (95)
HOLD_W, 16, width of sustain counter
MIN_HOLD, 1000, sustain length in CLK cycles after last key release

Ports:
CLK  input  1  system clock
RESETN  input  1  asynchronous active-low reset
KEY  input  N_KEYS  raw key levels, active high, asynchronous to CLK
PIEZO  output  1  square-wave drive to piezo
ACTIVE  output  1  high while a tone is sounding (including sustain)
NOTE  output  IDX_W  index of key currently sounding; valid when ACTIVE=1

Behaviour:
- Reset: one clock, CLK. Reset is asynchronous and active-low on RESETN. While RESETN=0: PIEZO=0, ACTIVE=0, NOTE=0, counter=0, sustain=0, synchroniser flops=0. Reset asserted mid-tone forces PIEZO low immediately, without waiting for CLK.
- Input sync: KEY passes through a 2-flop synchroniser. Sync latency is 2 cycles.
- Priority: the highest set index of the synchronised KEY wins, i.e. the lowest note. req_valid = any bit set.
- Effective terminal count T_eff = table[idx], clamped to a minimum of 1. The counter runs 0..T_eff. At CNT==T_eff, PIEZO toggles and CNT returns to 0. Half-period = T_eff+1 cycles.
- States: IDLE (ACTIVE=0) and PLAY (ACTIVE=1); sustain is PLAY with no key held.
- IDLE, req_valid=1, on the next edge:
  - ACTIVE=1, NOTE=idx, T latched, CNT=0, PIEZO=0.
  - First rising toggle occurs T+1 cycles later.
  - sustain=MIN_HOLD.
- PLAY, req_valid=1:
  - sustain is reloaded to MIN_HOLD every cycle.
  - If idx differs from NOTE, the change is pending. At the next CNT==T boundary, PIEZO toggles as normal, then NOTE and T take the new value.
  - No half-period is ever truncated or extended mid-count.
  - If idx reverts to NOTE before that boundary, the pending change is dropped.
- PLAY, req_valid=0, sustain>0: sustain decrements by 1 per cycle; the tone continues at the current NOTE.
- PLAY, req_valid=0, sustain==0: on the next edge go to IDLE with ACTIVE=0, PIEZO=0, CNT=0. NOTE holds its last value.
- Key pressed during sustain: stay in PLAY, reload sustain, and apply the pending-change rule.
- MIN_HOLD=0: IDLE is entered on the first cycle with no key held.
- Widths:
  - The counter is CNT_W bits and never exceeds T, so it cannot wrap.
  - The sustain counter saturates at 0; it never decrements below 0.

Optional Feature:
OCTAVE_SHIFT_EN
- Defined: adds input port OCT [1:0].
  - T_eff = ((table[idx]+1) >> OCT) - 1, clamped to a minimum of 1, so each OCT step raises the pitch by one octave.
  - OCT is sampled through the same 2-flop synchroniser as KEY.
  - A change of OCT is applied at the next half-period boundary, exactly like a note change.
- Undefined: no OCT port; T_eff = table[idx] clamped to a minimum of 1.

Test Plan:
- Reset then KEY=8'h80 held: ACTIVE=1 and NOTE=7 three cycles after KEY rises (2 sync + 1). PIEZO first rises 191 cycles later, then toggles every 191 cycles.
- KEY=8'h80 changed to 8'h01 at CNT=50: the current half-period completes at 191 cycles. The following half-periods are 96 cycles. NOTE switches to 0 at that boundary. No pulse is shorter than 96 cycles.
- KEY=8'h81: NOTE=7 (highest index wins), half-period 191.
- KEY=8'h04 then all keys released, MIN_HOLD=1000: the tone continues at 114-cycle half-periods for 1000 cycles after the synchronised release. ACTIVE and PIEZO drop to 0 on the following edge, and NOTE stays 2.
- RESETN pulsed low mid-half-period while PIEZO=1: PIEZO=0 and ACTIVE=0 without a CLK edge. After release with KEY held, playback restarts from CNT=0.
- With OCTAVE_SHIFT_EN, KEY=8'h80, OCT=1: half-period 95 cycles. OCT=3: half-period 23 cycles. OCT 0->1 mid-count takes effect only at the next toggle.

Source files
------------

// File: rtl/piezo_tone_gen_if.sv
// Keypad-to-piezo signal bundle for piezo_tone_gen.
// OCT exists only when OCTAVE_SHIFT_EN is defined.
interface piezo_tone_gen_if #(
  parameter int unsigned N_KEYS = 8,
  parameter int unsigned IDX_W  = 3
);
  logic [N_KEYS-1:0] KEY;
`ifdef OCTAVE_SHIFT_EN
  logic [1:0]        OCT;
`endif
  logic              PIEZO;
  logic              ACTIVE;
  logic [IDX_W-1:0]  NOTE;

  modport master (
`ifdef OCTAVE_SHIFT_EN
    output OCT,
`endif
    output KEY,
    input  PIEZO, ACTIVE, NOTE
  );

  modport slave (
`ifdef OCTAVE_SHIFT_EN
    input  OCT,
`endif
    input  KEY,
    output PIEZO, ACTIVE, NOTE
  );
endinterface

// File: rtl/piezo_tone_gen.sv
// Keypad piezo tone generator: synchronised keys, highest-index priority, glitch-free
// note changes at half-period boundaries and release sustain. Optional OCTAVE_SHIFT_EN.
//
// state  | meaning
// S_IDLE | silent, PIEZO=0, waiting for a key
// S_PLAY | tone sounding; with no key held this is the sustain phase
module piezo_tone_gen #(
  parameter int unsigned N_KEYS = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned CNT_W  = 8,
  parameter logic [N_KEYS*CNT_W-1:0] LIMIT_TABLE =
    {8'd190, 8'd169, 8'd151, 8'd142, 8'd127, 8'd113, 8'd100, 8'd95},
  parameter int unsigned HOLD_W   = 16,
  parameter int unsigned MIN_HOLD = 1000
) (
  input logic              CLK,
  input logic              RESETN,
  piezo_tone_gen_if.slave  bus
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);

  state_t            state_q, state_d;
  logic [N_KEYS-1:0] key_s1_q, key_s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, t_q, t_d, t_new, raw;
  logic [IDX_W-1:0]  note_q, note_d, idx, sel;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              piezo_q, piezo_d;
  logic              req_valid;
`ifdef OCTAVE_SHIFT_EN
  logic [1:0]        oct_s1_q, oct_s2_q;
  logic [CNT_W:0]    shifted;
`endif

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (key_s2_q[i]) idx = IDX_W'(i);
  end

  assign req_valid = |key_s2_q;
  // Without a key held the current note keeps its table entry (sustain).
  assign sel = req_valid ? idx : note_q;

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (sel == IDX_W'(i)) raw = LIMIT_TABLE[i*CNT_W +: CNT_W];
  end

`ifdef OCTAVE_SHIFT_EN
  always_comb begin
    shifted = ({1'b0, raw} + (CNT_W+1)'(1)) >> oct_s2_q;
    t_new   = (shifted <= (CNT_W+1)'(2)) ? CNT_W'(1) : CNT_W'(shifted - (CNT_W+1)'(1));
  end
`else
  assign t_new = (raw == '0) ? CNT_W'(1) : raw;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      key_s1_q <= '0;
      key_s2_q <= '0;
      cnt_q    <= '0;
      t_q      <= '0;
      note_q   <= '0;
      hold_q   <= '0;
      piezo_q  <= 1'b0;
`ifdef OCTAVE_SHIFT_EN
      oct_s1_q <= '0;
      oct_s2_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      key_s1_q <= bus.KEY;
      key_s2_q <= key_s1_q;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      note_q   <= note_d;
      hold_q   <= hold_d;
      piezo_q  <= piezo_d;
`ifdef OCTAVE_SHIFT_EN
      oct_s1_q <= bus.OCT;
      oct_s2_q <= oct_s1_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_PLAY;
      default: if (!req_valid && hold_q == '0) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    t_d     = t_q;
    note_d  = note_q;
    hold_d  = hold_q;
    piezo_d = piezo_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        piezo_d = 1'b0;
        hold_d  = '0;
        if (req_valid) begin
          note_d = idx;
          t_d    = t_new;
          hold_d = HOLD_INIT;
        end
      end
      default: begin
        if (req_valid)          hold_d = HOLD_INIT;
        else if (hold_q != '0)  hold_d = hold_q - 1'b1;
        if (!req_valid && hold_q == '0) begin
          cnt_d   = '0;
          piezo_d = 1'b0;
        end else if (cnt_q == t_q) begin
          // Pending note/octave changes take effect only here, so no half-period is cut short.
          cnt_d   = '0;
          piezo_d = ~piezo_q;
          note_d  = sel;
          t_d     = t_new;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.PIEZO  = piezo_q;
  assign bus.ACTIVE = (state_q == S_PLAY);
  assign bus.NOTE   = note_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Scoreboard bench for piezo_tone_gen: stimulus pushes expected output events,
// a negedge monitor pops one per observed change of {PIEZO, ACTIVE, NOTE}.
module tb_piezo_tone_gen;

  typedef struct {
    int         cyc;
    logic       p;
    logic       a;
    logic [2:0] n;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  ev_t  exp_q[$];

  piezo_tone_gen_if #(.N_KEYS(8), .IDX_W(3)) bus ();

  piezo_tone_gen dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input logic p, input logic a, input logic [2:0] n);
    ev_t e;
    e.cyc = c; e.p = p; e.a = a; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  logic       p_prev, a_prev;
  logic [2:0] n_prev;
  initial begin
    p_prev = 1'b0; a_prev = 1'b0; n_prev = 3'd0;
  end

  always @(negedge clk) begin
    ev_t e;
    if (bus.PIEZO !== p_prev || bus.ACTIVE !== a_prev || bus.NOTE !== n_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got p=%b a=%b n=%0d want none",
                 cyc, bus.PIEZO, bus.ACTIVE, bus.NOTE);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.p !== bus.PIEZO || e.a !== bus.ACTIVE || e.n !== bus.NOTE) begin
          errors++;
          $display("FAIL event got cyc=%0d p=%b a=%b n=%0d want cyc=%0d p=%b a=%b n=%0d",
                   cyc, bus.PIEZO, bus.ACTIVE, bus.NOTE, e.cyc, e.p, e.a, e.n);
        end
      end
      p_prev = bus.PIEZO;
      a_prev = bus.ACTIVE;
      n_prev = bus.NOTE;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.KEY = 8'h00;
`ifdef OCTAVE_SHIFT_EN
    bus.OCT = 2'd0;
`endif
    #1;
    check_bit("reset_piezo", bus.PIEZO, 1'b0);
    check_bit("reset_active", bus.ACTIVE, 1'b0);
    check_bit("reset_note0", bus.NOTE[0], 1'b0);

    wait_to(3);
    rst_n = 1'b1;

    // Lowest note: active 3 cycles after the key, half-period 191
    wait_to(10);
    bus.KEY = 8'h80;
    push(13, 1'b0, 1'b1, 3'd7);
    push(204, 1'b1, 1'b1, 3'd7);

    // Switch to high DO mid-count: current half completes, then 96-cycle halves
    wait_to(254);
    bus.KEY = 8'h01;
    push(395, 1'b0, 1'b1, 3'd0);
    push(491, 1'b1, 1'b1, 3'd0);
    push(587, 1'b0, 1'b1, 3'd0);

    // Two keys: highest index wins
    wait_to(600);
    bus.KEY = 8'h81;
    push(683, 1'b1, 1'b1, 3'd7);
    push(874, 0, 1'b1, 3'd7);

    // Pending change reverted before the boundary is dropped
    wait_to(900);
    bus.KEY = 8'h01;
    wait_to(920);
    bus.KEY = 8'h80;
    push(1065, 1'b1, 1'b1, 3'd7);

    // KEY[2] (T=113), then release and sustain
    wait_to(1100);
    bus.KEY = 8'h04;
    push(1256, 1'b0, 1'b1, 3'd2);
    for (int k = 1; k <= 11; k++)
      push(1256 + 114*k, (k % 2 == 1), 1'b1, 3'd2);

    wait_to(1550);
    bus.KEY = 8'h00;
    push(2553, 1'b0, 1'b0, 3'd2);

    // Async reset while PIEZO=1
    wait_to(2600);
    bus.KEY = 8'h80;
    push(2603, 1'b0, 1'b1, 3'd7);
    push(2794, 1'b1, 1'b1, 3'd7);

    wait_to(2850);
    @(posedge clk);
    #2;
    push(2851, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_piezo", bus.PIEZO, 1'b0);
    check_bit("async_rst_active", bus.ACTIVE, 1'b0);

    wait_to(2855);
    rst_n = 1'b1;
    push(2858, 1'b0, 1'b1, 3'd7);
    push(3049, 1'b1, 1'b1, 3'd7);

`ifdef OCTAVE_SHIFT_EN
    wait_to(3060);
    bus.OCT = 2'd1;
    push(3240, 1'b0, 1'b1, 3'd7);
    push(3335, 1'b1, 1'b1, 3'd7);
    push(3430, 1'b0, 1'b1, 3'd7);
    wait_to(3440);
    bus.OCT = 2'd3;
    push(3525, 1'b1, 1'b1, 3'd7);
    push(3548, 1'b0, 1'b1, 3'd7);
    push(3571, 1'b1, 1'b1, 3'd7);
    push(3594, 1'b0, 1'b1, 3'd7);
`else
    push(3240, 1'b0, 1'b1, 3'd7);
    push(3431, 1'b1, 1'b1, 3'd7);
`endif

    wait_to(3600);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got pending=%0d want 0 (next at cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
